// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - byte-stream to 32-bit word memory loader with core halt
module mem_loader #(
    parameter int ADDR_W = 11,
    parameter int CNT_W  = 12
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [CNT_W-1:0]  word_count_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic [ADDR_W-1:0] mem_address_o,
    output logic [31:0]       mem_Datain1_o,
    output logic [31:0]       mem_Datain2_o,
    output logic              mem_Wr_o,
    output logic              cpu_halt_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_COLLECT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]   remain_q, remain_d;
    logic [31:0]        data_q, data_d;
    logic [1:0]         idx_q, idx_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            data_q   <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            data_q   <= data_d;
            idx_q    <= idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        data_d     = data_q;
        idx_d      = idx_q;
        rx_ready_o = 1'b0;
        mem_Wr_o   = 1'b1;
        done_o     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    addr_d   = base_addr_i;
                    remain_d = word_count_i;
                    idx_d    = '0;
                    state_d  = S_HALT;
                end
            end
            S_HALT: begin
                state_d = (remain_q == '0) ? S_DONE : S_COLLECT;
            end
            S_COLLECT: begin
                rx_ready_o = 1'b1;
                if (rx_valid_i) begin
                    data_d[{idx_q, 3'b000} +: 8] = rx_data_i;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                mem_Wr_o = 1'b0;
                remain_d = remain_q - 1'b1;
                addr_d   = addr_q + 1'b1;
                state_d  = (remain_q == CNT_W'(1)) ? S_DONE : S_COLLECT;
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Abort overrides everything: no strobe, no pulse, no byte consumed.
        if (state_q != S_IDLE && abort_i) begin
            state_d    = S_IDLE;
            addr_d     = addr_q;
            remain_d   = remain_q;
            data_d     = data_q;
            idx_d      = '0;
            rx_ready_o = 1'b0;
            mem_Wr_o   = 1'b1;
            done_o     = 1'b0;
        end
    end

    assign mem_address_o = addr_q;
    assign mem_Datain1_o = data_q;
    assign mem_Datain2_o = '0;
    assign busy_o        = (state_q != S_IDLE);
    assign cpu_halt_o    = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_loader.sv
// tb/tb_mem_loader.sv - self-checking bench for mem_loader
module tb_mem_loader;
    localparam int AW = 11;
    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, abort_s;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] word_count;
    logic [7:0]    rx_data;
    logic          rx_valid, rx_ready;
    logic [AW-1:0] mem_address;
    logic [31:0]   mem_d1, mem_d2;
    logic          mem_wr, cpu_halt, busy, done;

    mem_loader #(.ADDR_W(AW), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .abort_i(abort_s),
        .base_addr_i(base_addr), .word_count_i(word_count),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
        .mem_address_o(mem_address), .mem_Datain1_o(mem_d1), .mem_Datain2_o(mem_d2),
        .mem_Wr_o(mem_wr), .cpu_halt_o(cpu_halt), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int d2_bad   = 0;
    logic [AW-1:0] obs_addr[$];
    logic [31:0]   obs_data[$];
    int            obs_cyc[$];
    logic [7:0]    tx_bytes[$];
    logic [AW-1:0] exp_addr[$];
    logic [31:0]   exp_data[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (!mem_wr) begin
                obs_addr.push_back(mem_address);
                obs_data.push_back(mem_d1);
                obs_cyc.push_back(cyc);
            end
            if (done) done_cnt++;
            if (mem_d2 !== 32'd0) d2_bad++;
        end
    end

    task automatic clear_obs();
        obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic make_bytes(input int cnt);
        tx_bytes.delete();
        for (int i = 0; i < 4 * cnt; i++) tx_bytes.push_back(8'($urandom));
    endtask

    // Reference: word i goes to (base+i) mod 2^AW, little-endian byte packing.
    task automatic build_model(input int base, input int cnt);
        exp_addr.delete(); exp_data.delete();
        for (int i = 0; i < cnt; i++) begin
            exp_addr.push_back(AW'((base + i) % (1 << AW)));
            exp_data.push_back({tx_bytes[4*i+3], tx_bytes[4*i+2], tx_bytes[4*i+1], tx_bytes[4*i]});
        end
    endtask

    task automatic start_session(input int base, input int cnt);
        @(posedge clk); #1;
        start = 1'b1; base_addr = AW'(base); word_count = CW'(cnt);
        @(posedge clk); #1;
        start = 1'b0; base_addr = AW'($urandom); word_count = CW'($urandom);
    endtask

    // mode 0: valid held high, 1: valid every other cycle, 2: random valid plus stray starts
    task automatic feed(input int mode);
        int idx = 0;
        int budget = 400;
        int ph = 0;
        bit acc;
        while (idx < tx_bytes.size() && budget > 0) begin
            case (mode)
                0: rx_valid = 1'b1;
                1: rx_valid = ph[0];
                default: rx_valid = (($urandom % 3) != 0);
            endcase
            ph++;
            rx_data = tx_bytes[idx];
            if (mode == 2) begin
                start = (($urandom % 6) == 0);
                base_addr = AW'($urandom); word_count = CW'($urandom);
            end
            @(negedge clk);
            acc = rx_valid && rx_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            budget--;
        end
        rx_valid = 1'b0; start = 1'b0;
        if (idx < tx_bytes.size()) begin
            n_checks++; n_fail++;
            $display("FAIL feed_timeout: accepted %0d bytes, required %0d", idx, tx_bytes.size());
        end
    endtask

    task automatic wait_idle();
        int budget = 50;
        @(negedge clk);
        while (busy && budget > 0) begin @(negedge clk); budget--; end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_timeout: busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({rx_ready, mem_wr, cpu_halt, busy, done} !== 5'b01000) begin
            n_fail++;
            $display("FAIL reset_ctrl: {rdy,wr,halt,busy,done}=%b required 01000", {rx_ready, mem_wr, cpu_halt, busy, done});
        end
        n_checks++;
        if (mem_address !== '0 || mem_d1 !== 32'd0 || mem_d2 !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%h d1=%h d2=%h required 0", mem_address, mem_d1, mem_d2);
        end
    endtask

    task automatic test_basic();
        clear_obs();
        tx_bytes.delete();
        for (int i = 1; i <= 8; i++) tx_bytes.push_back(8'(i * 8'h11));
        build_model(12'h010, 2);
        start_session(12'h010, 2);
        feed(0);
        wait_idle();
        n_checks++;
        if (obs_addr.size() !== 2) begin
            n_fail++; $display("FAIL basic_count: writes=%0d required 2", obs_addr.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                    n_fail++;
                    $display("FAIL basic_word%0d: %h@%h required %h@%h", i, obs_data[i], obs_addr[i], exp_data[i], exp_addr[i]);
                end
            end
        end
        n_checks++;
        if (done_cnt !== 1 || cpu_halt !== 1'b0) begin
            n_fail++; $display("FAIL basic_done: pulses=%0d halt=%b required 1,0", done_cnt, cpu_halt);
        end
    endtask

    task automatic test_zero_count();
        clear_obs();
        start_session(0, 0);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || cpu_halt !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL zero_halt: busy=%b halt=%b done=%b required 1,1,0", busy, cpu_halt, done);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++; $display("FAIL zero_done: done=%b required 1", done);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || obs_addr.size() !== 0 || done_cnt !== 1) begin
            n_fail++; $display("FAIL zero_end: busy=%b writes=%0d pulses=%0d required 0,0,1", busy, obs_addr.size(), done_cnt);
        end
    endtask

    task automatic test_session(input string name, input int base, input int cnt, input int mode);
        clear_obs();
        make_bytes(cnt);
        build_model(base, cnt);
        start_session(base, cnt);
        feed(mode);
        wait_idle();
        n_checks++;
        if (obs_addr.size() !== cnt || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL %s_count: writes=%0d pulses=%0d required %0d,1", name, obs_addr.size(), done_cnt, cnt);
        end else begin
            for (int i = 0; i < cnt; i++) begin
                n_checks++;
                if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                    n_fail++;
                    $display("FAIL %s_word%0d: %h@%h required %h@%h", name, i, obs_data[i], obs_addr[i], exp_data[i], exp_addr[i]);
                end
            end
        end
    endtask

    task automatic test_throughput();
        test_session("tput", $urandom_range(0, 2047), 3, 0);
        for (int i = 1; i < obs_cyc.size(); i++) begin
            n_checks++;
            if (obs_cyc[i] - obs_cyc[i-1] !== 5) begin
                n_fail++; $display("FAIL tput_gap%0d: %0d cycles required 5", i, obs_cyc[i] - obs_cyc[i-1]);
            end
        end
    endtask

    task automatic test_abort_collect();
        clear_obs();
        make_bytes(2);
        tx_bytes = tx_bytes[0:1];
        start_session(12'h123, 2);
        feed(0);
        abort_s = 1'b1;
        @(posedge clk); #1;
        abort_s = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || obs_addr.size() !== 0 || done_cnt !== 0) begin
            n_fail++; $display("FAIL abort_collect: busy=%b writes=%0d pulses=%0d required 0,0,0", busy, obs_addr.size(), done_cnt);
        end
        test_session("post_abort", 12'h123, 2, 0);
    endtask

    task automatic test_abort_write();
        clear_obs();
        make_bytes(2);
        tx_bytes = tx_bytes[0:3];
        start_session($urandom_range(0, 2047), 2);
        feed(0);
        abort_s = 1'b1;
        @(posedge clk); #1;
        abort_s = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || obs_addr.size() !== 0 || done_cnt !== 0) begin
            n_fail++; $display("FAIL abort_write: busy=%b writes=%0d pulses=%0d required 0,0,0", busy, obs_addr.size(), done_cnt);
        end
    endtask

    task automatic test_reset_write();
        clear_obs();
        make_bytes(2);
        tx_bytes = tx_bytes[0:3];
        start_session(12'h2AA, 2);
        feed(0);
        n_checks++;
        if (mem_wr !== 1'b0) begin
            n_fail++; $display("FAIL rstw_in_write: mem_wr=%b required 0", mem_wr);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rx_ready, mem_wr, cpu_halt, busy, done} !== 5'b01000 || mem_address !== '0 || mem_d1 !== 32'd0) begin
            n_fail++;
            $display("FAIL rstw_outputs: {rdy,wr,halt,busy,done}=%b addr=%h d1=%h required 01000,0,0",
                     {rx_ready, mem_wr, cpu_halt, busy, done}, mem_address, mem_d1);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_checks++;
        if (obs_addr.size() !== 0 || done_cnt !== 0) begin
            n_fail++; $display("FAIL rstw_side: writes=%0d pulses=%0d required 0,0", obs_addr.size(), done_cnt);
        end
        test_session("post_reset", $urandom_range(0, 2047), 2, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort_s = 1'b0; base_addr = '0; word_count = '0;
        rx_data = '0; rx_valid = 1'b0;
        #23;
        test_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        test_basic();
        test_zero_count();
        test_session("wrap", 12'h7FF, 2, 0);
        test_session("toggle", $urandom_range(0, 2047), 3, 1);
        test_throughput();
        test_abort_collect();
        test_abort_write();
        test_reset_write();
        for (int s = 0; s < 6; s++) test_session("rand", $urandom_range(0, 2047), $urandom_range(1, 4), 2);
        n_checks++;
        if (d2_bad !== 0) begin
            n_fail++; $display("FAIL datain2_zero: %0d nonzero cycles required 0", d2_bad);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
